// File: rtl/viterbi_traceback_pkg.sv
// Shared constants and helpers for the Viterbi survivor-path traceback stage.
package viterbi_traceback_pkg;
  localparam int ST_W      = 6;
  localparam int BLK_LEN   = 32;
  localparam int NUM_BANKS = 4;
  localparam int RD_LAT    = 2;
  localparam int CNT_W     = $clog2(BLK_LEN);

  localparam logic [1:0] BANK_A = 2'd0;
  localparam logic [1:0] BANK_B = 2'd1;
  localparam logic [1:0] BANK_C = 2'd2;
  localparam logic [1:0] BANK_D = 2'd3;

  function automatic logic [1:0] bank_sel(input logic [1:0] m, input logic [1:0] offset);
    return 2'((int'(m) + int'(offset)) % NUM_BANKS);
  endfunction
endpackage

// File: rtl/viterbi_traceback_if.sv
// Survivor-memory read ports, control and decoded-bit output of the traceback stage.
interface viterbi_traceback_if;
  import viterbi_traceback_pkg::*;

  logic            process_en;
  logic            d_in_valid;
  logic [1:0]      mem_bank;
  logic [63:0]     d_o_mem_A;
  logic [63:0]     d_o_mem_B;
  logic [63:0]     d_o_mem_C;
  logic [63:0]     d_o_mem_D;
  logic [ST_W-1:0] best_state;
  logic            dec_bit;
  logic            dec_valid;
  logic [ST_W-1:0] tb_state;

  modport master (
    output process_en, d_in_valid, mem_bank, d_o_mem_A, d_o_mem_B, d_o_mem_C, d_o_mem_D,
           best_state,
    input  dec_bit, dec_valid, tb_state
  );

  modport slave (
    input  process_en, d_in_valid, mem_bank, d_o_mem_A, d_o_mem_B, d_o_mem_C, d_o_mem_D,
           best_state,
    output dec_bit, dec_valid, tb_state
  );
endinterface

// File: rtl/viterbi_traceback_lifo.sv
// Ping-pong reversal buffer: a decode pass fills one half backwards in time,
// the other half is drained oldest-first one bit per step.
module tb_lifo
  import viterbi_traceback_pkg::*;
(
  input  logic             clk,
  input  logic             RSTn,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_idx,
  input  logic             wr_bit,
  input  logic             wr_last,
  input  logic             rd_step,
  output logic             rd_bit,
  output logic             rd_valid
);
  localparam logic [CNT_W-1:0] IDX_MAX = CNT_W'(BLK_LEN - 1);

  logic [1:0][BLK_LEN-1:0] mem;
  logic [1:0]              full;
  logic                    w_half;
  logic                    r_half;
  logic [CNT_W-1:0]        rd_idx;
  logic                    rd_go;

  assign rd_go = rd_step & full[r_half];

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      mem      <= '0;
      full     <= '0;
      w_half   <= 1'b0;
      r_half   <= 1'b0;
      rd_idx   <= '0;
      rd_bit   <= 1'b0;
      rd_valid <= 1'b0;
    end else if (flush) begin
      full     <= '0;
      w_half   <= 1'b0;
      r_half   <= 1'b0;
      rd_idx   <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_go;
      if (rd_go) begin
        rd_bit <= mem[r_half][rd_idx];
        rd_idx <= rd_idx + 1'b1;
        if (rd_idx == IDX_MAX) begin
          full[r_half] <= 1'b0;
          r_half       <= ~r_half;
        end
      end
      // Read and write halves differ once draining has begun, so these never collide.
      if (wr_en) begin
        mem[w_half][wr_idx] <= wr_bit;
        if (wr_last) begin
          full[w_half] <= 1'b1;
          w_half       <= ~w_half;
        end
      end
    end
  end
endmodule

// File: rtl/viterbi_traceback.sv
// Training + decode traceback over the 4-bank survivor memory; emits one
// decoded bit per cycle in chronological order once four blocks are primed.
module viterbi_traceback
  import viterbi_traceback_pkg::*;
(
  input  logic               clk,
  input  logic               RSTn,
  viterbi_traceback_if.slave bus
);
  localparam logic [CNT_W-1:0] A_MAX = CNT_W'(BLK_LEN - 1);

  logic                          en;
  logic [CNT_W-1:0]              cnt;
  logic [RD_LAT-1:0]             pv;
  logic [RD_LAT-1:0][CNT_W-1:0]  pa;
  logic [RD_LAT-1:0][1:0]        pm;

  logic                          v;
  logic [CNT_W-1:0]              a;
  logic [1:0]                    m;
  logic                          start;
  logic                          last;

  logic [63:0]                   vec_tr;
  logic [63:0]                   vec_dc;
  logic [ST_W-1:0]               ts, ds, tr_final;
  logic [ST_W-1:0]               ts_cur, ds_cur, ts_nxt, ds_nxt;
  logic [1:0]                    blk_seen;
  logic                          dec_act;
  logic                          dec_act_cur;

  assign en = bus.process_en | bus.d_in_valid;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
      pv  <= '0;
      pa  <= '0;
      pm  <= '0;
    end else if (!en) begin
      cnt <= '0;
      pv  <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      pv  <= {pv[RD_LAT-2:0], 1'b1};
      pa  <= {pa[RD_LAT-2:0], A_MAX - cnt};
      pm  <= {pm[RD_LAT-2:0], bus.mem_bank};
    end
  end

  // An abort in the same cycle as a pass end wins: the slot is discarded.
  assign v     = pv[RD_LAT-1] & en;
  assign a     = pa[RD_LAT-1];
  assign m     = pm[RD_LAT-1];
  assign start = v && (a == A_MAX);
  assign last  = v && (a == '0);

  always_comb begin
    vec_tr = bus.d_o_mem_A;
    vec_dc = bus.d_o_mem_A;
    case (bank_sel(m, 2'd3))
      BANK_B:  vec_tr = bus.d_o_mem_B;
      BANK_C:  vec_tr = bus.d_o_mem_C;
      BANK_D:  vec_tr = bus.d_o_mem_D;
      default: vec_tr = bus.d_o_mem_A;
    endcase
    case (bank_sel(m, 2'd1))
      BANK_B:  vec_dc = bus.d_o_mem_B;
      BANK_C:  vec_dc = bus.d_o_mem_C;
      BANK_D:  vec_dc = bus.d_o_mem_D;
      default: vec_dc = bus.d_o_mem_A;
    endcase
  end

  assign ts_cur      = start ? bus.best_state : ts;
  assign ds_cur      = start ? tr_final : ds;
  assign ts_nxt      = {ts_cur[ST_W-2:0], vec_tr[ts_cur]};
  assign ds_nxt      = {ds_cur[ST_W-2:0], vec_dc[ds_cur]};
  assign dec_act_cur = start ? (blk_seen == 2'd3) : dec_act;

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      ts       <= '0;
      ds       <= '0;
      tr_final <= '0;
      blk_seen <= '0;
      dec_act  <= 1'b0;
    end else if (!en) begin
      tr_final <= '0;
      blk_seen <= '0;
      dec_act  <= 1'b0;
    end else if (v) begin
      ts      <= ts_nxt;
      ds      <= ds_nxt;
      dec_act <= dec_act_cur;
      if (last) begin
        tr_final <= ts_nxt;
        if (blk_seen != 2'd3) blk_seen <= blk_seen + 1'b1;
      end
    end
  end

  tb_lifo u_lifo (
    .clk      (clk),
    .RSTn     (RSTn),
    .flush    (!en),
    .wr_en    (v & dec_act_cur),
    .wr_idx   (a),
    .wr_bit   (ds_cur[ST_W-1]),
    .wr_last  (last),
    .rd_step  (v),
    .rd_bit   (bus.dec_bit),
    .rd_valid (bus.dec_valid)
  );

  assign bus.tb_state = ds;
endmodule

// File: tb/tb_viterbi_traceback.sv
// Scoreboard bench for viterbi_traceback: a block-level traceback model
// queues expected bits, a negedge monitor pops them as dec_valid appears.
module tb_viterbi_traceback;
  import viterbi_traceback_pkg::*;

  logic clk = 1'b0;
  logic RSTn = 1'b0;
  viterbi_traceback_if bus();

  viterbi_traceback dut (
    .clk  (clk),
    .RSTn (RSTn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  bit          q[$];
  bit          exp_bit;
  logic [63:0] bank_vec [4];
  int          en_cyc = 0;
  bit          first_seen = 1'b0;
  bit          ones_mode = 1'b0;
  bit          running = 1'b0;

  localparam int FIRST_VALID = 4 * BLK_LEN + RD_LAT + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic apply_banks();
    bus.d_o_mem_A = bank_vec[0];
    bus.d_o_mem_B = bank_vec[1];
    bus.d_o_mem_C = bank_vec[2];
    bus.d_o_mem_D = bank_vec[3];
  endtask

  function automatic logic [5:0] train(input logic [63:0] vec, input logic [5:0] s0);
    logic [5:0] s;
    s = s0;
    for (int i = 0; i < BLK_LEN; i++) s = {s[4:0], vec[s]};
    return s;
  endfunction

  task automatic push_decode(input logic [63:0] vec, input logic [5:0] s0);
    logic [5:0] s;
    bit bits [BLK_LEN];
    s = s0;
    for (int a = BLK_LEN - 1; a >= 0; a--) begin
      bits[a] = s[5];
      s = {s[4:0], vec[s]};
    end
    for (int i = 0; i < BLK_LEN; i++) q.push_back(bits[i]);
  endtask

  always @(posedge clk) begin
    if (!RSTn || !(bus.process_en || bus.d_in_valid)) en_cyc = 0;
    else en_cyc++;
  end

  always @(negedge clk) begin
    if (bus.dec_valid) begin
      if (!first_seen) begin
        chk("first_valid_cycle", 64'(en_cyc), 64'(FIRST_VALID));
        first_seen = 1'b1;
      end
      if (q.size() == 0) chk("unexpected_valid", 64'(1), 64'(0));
      else begin
        exp_bit = q.pop_front();
        chk("dec_bit", 64'(bus.dec_bit), 64'(exp_bit));
        if (ones_mode) chk("tb_state_ones", 64'(bus.tb_state), 64'(63));
      end
    end else if (running && first_seen && q.size() > 0) begin
      chk("no_gap", 64'(bus.dec_valid), 64'(1));
    end
  end

  // mode 0: run nblk blocks then drain; 1: abort at cnt 17 of block nblk;
  // 2: reset pulse at cnt 10 of block nblk. bmode 0..3 fixed bank, 4 rotating.
  task automatic run(input int nblk, input int mode, input int bmode,
                     input logic [5:0] best, input bit ones);
    logic [5:0] trf;
    logic [1:0] m;
    trf        = '0;
    first_seen = 1'b0;
    ones_mode  = ones;
    bus.best_state = best;
    apply_banks();
    for (int k = 0; k < nblk; k++) begin
      m = (bmode == 4) ? 2'(k % 4) : 2'(bmode);
      bus.mem_bank   = m;
      bus.process_en = 1'b1;
      bus.d_in_valid = 1'b1;
      running        = 1'b1;
      if (k >= 3 && (mode != 0 || k <= nblk - 2))
        push_decode(bank_vec[2'(m + 2'd1)], trf);
      trf = train(bank_vec[2'(m + 2'd3)], best);
      repeat (BLK_LEN) @(negedge clk);
    end
    bus.mem_bank = (bmode == 4) ? 2'(nblk % 4) : 2'(bmode);
    if (mode == 0) begin
      repeat (RD_LAT) @(negedge clk);
      running = 1'b0;
      bus.process_en = 1'b0;
      bus.d_in_valid = 1'b0;
      @(negedge clk);
      chk("drain_empty", 64'(q.size()), 64'(0));
      chk("valid_after_stop", 64'(bus.dec_valid), 64'(0));
    end else if (mode == 1) begin
      repeat (17) @(negedge clk);
      running = 1'b0;
      bus.process_en = 1'b0;
      bus.d_in_valid = 1'b0;
      @(negedge clk);
      chk("abort_valid", 64'(bus.dec_valid), 64'(0));
      chk("abort_pending", 64'(q.size()), 64'(17));
      q.delete();
    end else begin
      repeat (10) @(negedge clk);
      running = 1'b0;
      RSTn = 1'b0;
      bus.process_en = 1'b0;
      bus.d_in_valid = 1'b0;
      #1;
      chk("rst_dec_valid", 64'(bus.dec_valid), 64'(0));
      chk("rst_dec_bit", 64'(bus.dec_bit), 64'(0));
      chk("rst_tb_state", 64'(bus.tb_state), 64'(0));
      q.delete();
      @(negedge clk);
      RSTn = 1'b1;
      repeat (40) @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.process_en = 1'b0;
    bus.d_in_valid = 1'b0;
    bus.mem_bank   = 2'd0;
    bus.best_state = '0;
    for (int i = 0; i < 4; i++) bank_vec[i] = '0;
    apply_banks();
    repeat (3) @(negedge clk);
    chk("reset_dec_bit", 64'(bus.dec_bit), 64'(0));
    chk("reset_dec_valid", 64'(bus.dec_valid), 64'(0));
    chk("reset_tb_state", 64'(bus.tb_state), 64'(0));
    RSTn = 1'b1;
    repeat (2) @(negedge clk);

    // All zeros: 256 zero bits after priming
    run(12, 0, 4, 6'd0, 1'b0);

    // All ones
    for (int i = 0; i < 4; i++) bank_vec[i] = '1;
    run(8, 0, 4, 6'd0, 1'b1);

    // Only bank D populated
    for (int i = 0; i < 4; i++) bank_vec[i] = '0;
    bank_vec[3] = 64'h5555_5555_5555_5555;
    run(8, 0, 4, 6'h2A, 1'b0);

    // Fixed bank index with distinct random contents per bank
    for (int mb = 0; mb < 4; mb++) begin
      for (int i = 0; i < 4; i++) bank_vec[i] = {$urandom, $urandom};
      run(6, 0, mb, 6'($urandom_range(0, 63)), 1'b0);
    end

    // Abort in block 5, then priming restarts
    for (int i = 0; i < 4; i++) bank_vec[i] = {$urandom, $urandom};
    run(5, 1, 4, 6'd17, 1'b0);
    run(7, 0, 4, 6'd17, 1'b0);

    // Reset pulse mid-output, then a clean run
    for (int i = 0; i < 4; i++) bank_vec[i] = '1;
    run(5, 2, 4, 6'd0, 1'b1);
    for (int i = 0; i < 4; i++) bank_vec[i] = {$urandom, $urandom};
    run(6, 0, 4, 6'd45, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule
